// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the dither LFSR generator and checker.
//   - Default LFSR width, Galois tap mask and generator seed.
//   - lfsr_state_e: checker synchronisation state.
//   - lfsr_step(): one Galois step for widths up to 64 bits.
//   - popcount(): set-bit count. The checker uses it when it is built with
//     LFSR_CHECKER_BITERR_EN, so that it counts bit errors.
package lfsr_pkg;

  localparam int          LFSR_BITS_DEF = 32;
  localparam logic [31:0] LFSR_MASK_DEF = 32'h4600_0000;
  localparam logic [31:0] LFSR_SEED_DEF = 32'hed02_c8a9;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lfsr_state_e;

  // The word shifts right by one. The old LSB wraps into the MSB and is also
  // XORed into the tapped positions. Only mask bits [bits-2:0] take part.
  function automatic logic [63:0] lfsr_step(input logic [63:0] x,
                                            input logic [63:0] mask,
                                            input int          bits);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      if (i < bits - 1) y[i] = x[i+1] ^ (x[0] & mask[i]);
    end
    y[bits-1] = x[0];
    return y;
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// lfsr_next: combinational single Galois LFSR step. The generator and the
// checker both instantiate it, so both ends advance the sequence the same way.
// Ports:
//   x  in  BITS  current word
//   y  out BITS  next word
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int              BITS = LFSR_BITS_DEF,
  parameter logic [BITS-1:0] MASK = BITS'(LFSR_MASK_DEF)
) (
  input  logic [BITS-1:0] x,
  output logic [BITS-1:0] y
);

  assign y = BITS'(lfsr_step(64'(x), 64'(MASK), BITS));

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side self-synchronising checker for the dither LFSR.
// In SEARCH it re-seeds a prediction from every received word. After LOCK_CNT
// consecutive correct predictions it declares lock. It then flywheels its own
// LFSR copy, counts mispredicted words and drops lock after LOSS_CNT
// consecutive misses.
// Build option: if LFSR_CHECKER_BITERR_EN is defined, err_count accumulates
// the number of differing bits instead of the number of words.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   din        in   BITS   received LFSR word
//   din_valid  in   din is sampled this cycle
//   clr_err    in   synchronous clear of err_count (wins over an increment)
//   locked     out  checker is synchronised
//   err_pulse  out  one-cycle flag: the previous valid word mismatched while locked
//   err_count  out  ERR_W  saturating error count
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int              BITS     = LFSR_BITS_DEF,
  parameter logic [BITS-1:0] MASK     = BITS'(LFSR_MASK_DEF),
  parameter int              LOCK_CNT = 8,
  parameter int              LOSS_CNT = 4,
  parameter int              ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BITS-1:0]  din,
  input  logic             din_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [8:0]       LOCK_LIM = 9'(LOCK_CNT);
  localparam logic [8:0]       LOSS_LIM = 9'(LOSS_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam int               SUM_W    = ERR_W + 8;

  lfsr_state_e      state_q, state_d;
  logic [BITS-1:0]  pred_q, pred_d;
  logic             pred_vld_q, pred_vld_d;
  logic [7:0]       run_cnt_q, run_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic [BITS-1:0]  step_din;
  logic [BITS-1:0]  step_pred;
  logic [8:0]       run_inc;
  logic [6:0]       err_inc;
  logic             hit;

  // The step of the received word is used to re-seed in SEARCH. The step of
  // the prediction is used to flywheel in LOCKED.
  lfsr_next #(.BITS(BITS), .MASK(MASK)) u_next_din (
    .x (din),
    .y (step_din)
  );

  lfsr_next #(.BITS(BITS), .MASK(MASK)) u_next_pred (
    .x (pred_q),
    .y (step_pred)
  );

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                               input logic [6:0]       inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(inc);
    if (s > SUM_W'(ERR_MAX)) return ERR_MAX;
    return s[ERR_W-1:0];
  endfunction

  // Run counter plus one, one bit wider, so that a count of 255 compares cleanly.
  assign run_inc = {1'b0, run_cnt_q} + 9'd1;

`ifdef LFSR_CHECKER_BITERR_EN
  assign err_inc = 7'(popcount(64'(din ^ pred_q)));
`else
  assign err_inc = 7'd1;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEARCH;
      pred_q      <= '0;
      pred_vld_q  <= 1'b0;
      run_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      pred_vld_q  <= pred_vld_d;
      run_cnt_q   <= run_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    pred_vld_d  = pred_vld_q;
    run_cnt_d   = run_cnt_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    hit         = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        SEARCH: begin
          // An all-zero word is the LFSR lock-up state and never confirms a
          // prediction.
          hit        = pred_vld_q && (din == pred_q) && (din != '0);
          pred_d     = step_din;
          pred_vld_d = (din != '0);
          if (hit) begin
            if (run_inc == LOCK_LIM) begin
              state_d   = LOCKED;
              locked_d  = 1'b1;
              run_cnt_d = '0;
            end else begin
              run_cnt_d = run_inc[7:0];
            end
          end else begin
            run_cnt_d = '0;
          end
        end
        LOCKED: begin
          pred_d = step_pred;
          if (din != pred_q) begin
            err_pulse_d = 1'b1;
            err_count_d = sat_add(err_count_q, err_inc);
            if (run_inc == LOSS_LIM) begin
              state_d    = SEARCH;
              locked_d   = 1'b0;
              pred_vld_d = 1'b0;
              run_cnt_d  = '0;
            end else begin
              run_cnt_d = run_inc[7:0];
            end
          end else begin
            run_cnt_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (clr_err) err_count_d = '0;
  end

  // Outputs come straight from flops
  always_comb begin
    locked    = locked_q;
    err_pulse = err_pulse_q;
    err_count = err_count_q;
  end

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;

  localparam logic [31:0] MASK = 32'h4600_0000;
  localparam logic [31:0] SEED = 32'hed02_c8a9;
  localparam int          LOCK = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] din = '0;
  logic        locked0, pulse0, locked1, pulse1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  always #5 clk = ~clk;

  // Instance 0 uses the default parameters. Instance 1 uses a narrow
  // counter and a lock that is practically never lost.
  lfsr_checker #(.BITS(32), .MASK(MASK), .LOCK_CNT(8), .LOSS_CNT(4), .ERR_W(16)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_err(clr_err),
    .locked(locked0), .err_pulse(pulse0), .err_count(cnt0));

  lfsr_checker #(.BITS(32), .MASK(MASK), .LOCK_CNT(8), .LOSS_CNT(255), .ERR_W(4)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_err(clr_err),
    .locked(locked1), .err_pulse(pulse1), .err_count(cnt1));

  typedef struct {
    bit lk;
    bit pl;
    int cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_miss = 0;

  // Reference model state, one entry per instance
  bit          m_lk[2];
  bit          m_pv[2];
  bit          m_pl[2];
  logic [31:0] m_pred[2];
  int          m_run[2];
  int          m_err[2];
  logic [31:0] g;   // generator word for the next transmission

  function automatic int loss_of(int k);
    return (k == 0) ? 4 : 255;
  endfunction

  function automatic int max_of(int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  // Galois step written as shift and conditional XOR. The tap mask drops its
  // top bit, and the old LSB lands in bit 31.
  function automatic logic [31:0] gstep(logic [31:0] x);
    logic [31:0] t;
    t = (MASK & 32'h7fff_ffff) | 32'h8000_0000;
    return (x >> 1) ^ (x[0] ? t : 32'h0);
  endfunction

  function automatic logic [31:0] rnd_nz();
    logic [31:0] r;
    do r = $urandom; while (r == 32'h0);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lk[k] = 0; m_pv[k] = 0; m_pl[k] = 0;
      m_pred[k] = '0; m_run[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step(int k, bit v, logic [31:0] d, bit clr);
    bit hit;
    int inc;
    m_pl[k] = 0;
    if (v) begin
      if (!m_lk[k]) begin
        hit = m_pv[k] && (d == m_pred[k]) && (d != 0);
        m_pred[k] = gstep(d);
        m_pv[k] = (d != 0);
        if (hit) begin
          m_run[k]++;
          if (m_run[k] == LOCK) begin m_lk[k] = 1; m_run[k] = 0; end
        end else m_run[k] = 0;
      end else begin
        if (d != m_pred[k]) begin
          m_pl[k] = 1;
`ifdef LFSR_CHECKER_BITERR_EN
          inc = $countones(d ^ m_pred[k]);
`else
          inc = 1;
`endif
          m_err[k] = (m_err[k] + inc > max_of(k)) ? max_of(k) : m_err[k] + inc;
          m_run[k]++;
          if (m_run[k] == loss_of(k)) begin
            m_lk[k] = 0; m_pv[k] = 0; m_run[k] = 0;
          end
        end else m_run[k] = 0;
        m_pred[k] = gstep(m_pred[k]);
      end
    end
    if (clr) m_err[k] = 0;
  endtask

  // One clock of stimulus: drive on the falling edge, then queue what each
  // instance must show after the next rising edge.
  task automatic send(bit v, logic [31:0] d, bit clr);
    @(negedge clk);
    din_valid = v; din = d; clr_err = clr;
    for (int k = 0; k < 2; k++) model_step(k, v, d, clr);
    q0.push_back('{m_lk[0], m_pl[0], m_err[0]});
    q1.push_back('{m_lk[1], m_pl[1], m_err[1]});
  endtask

  task automatic word(logic [31:0] flip, bit clr = 0);
    send(1'b1, g ^ flip, clr);
    g = gstep(g);
  endtask

  task automatic gap();
    send(1'b0, $urandom, 1'b0);
  endtask

  task automatic probe();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_locked0"}, locked0, 0);
    chk({tag, "_pulse0"}, pulse0, 0);
    chk({tag, "_cnt0"}, cnt0, 0);
    chk({tag, "_locked1"}, locked1, 0);
    chk({tag, "_pulse1"}, pulse1, 0);
    chk({tag, "_cnt1"}, cnt1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0; clr_err = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    g = SEED;
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("sb_locked0", locked0, e.lk);
      chk("sb_pulse0", pulse0, e.pl);
      chk("sb_cnt0", cnt0, e.cnt);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("sb_locked1", locked1, e.lk);
      chk("sb_pulse1", pulse1, e.pl);
      chk("sb_cnt1", cnt1, e.cnt);
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r;
    model_reset();
    g = SEED;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Clean lock: the seed word followed by 8 hits
    repeat (8) word(0);
    probe();
    chk("lock_after8", locked0, 0);
    word(0);
    probe();
    chk("lock_after9", locked0, 1);
    chk("lock_cnt0", cnt0, 0);
    chk("lock_inst1", locked1, 1);

    // Single bit error, then a clean word
    word(32'h1);
    probe();
    chk("single_pulse", pulse0, 1);
    chk("single_cnt", cnt0, 1);
    chk("single_locked", locked0, 1);
    word(0);
    probe();
    chk("single_next_pulse", pulse0, 0);
    chk("single_next_cnt", cnt0, 1);

    // Loss of lock after 4 random words, then relock
    word(0, 1'b1);
    probe();
    chk("clr_cnt", cnt0, 0);
    repeat (3) word(rnd_nz());
    probe();
    chk("loss_after3", locked0, 1);
    word(rnd_nz());
    probe();
    chk("loss_after4", locked0, 0);
`ifndef LFSR_CHECKER_BITERR_EN
    chk("loss_cnt", cnt0, 4);
`endif
    repeat (8) word(0);
    probe();
    chk("relock_after8", locked0, 0);
    word(0);
    probe();
    chk("relock_after9", locked0, 1);

    // Zero words in SEARCH
    do_reset();
    repeat (10) send(1'b1, 32'h0, 1'b0);
    probe();
    chk("zero_locked", locked0, 0);
    chk("zero_pred_vld", dut0.pred_vld_q, 0);
    repeat (9) word(0);
    probe();
    chk("zero_then_lock", locked0, 1);

    // Saturation on the 4-bit counter, and a clear that wins over an error
    repeat (20) word(rnd_nz());
    probe();
    chk("sat_cnt1", cnt1, 15);
    chk("sat_locked1", locked1, 1);
    word(rnd_nz(), 1'b1);
    probe();
    chk("clr_vs_err_cnt1", cnt1, 0);
    chk("clr_vs_err_pulse1", pulse1, 1);

    // Relock, reset mid-lock, then a sequence with din_valid gaps
    repeat (9) word(0);
    probe();
    chk("pre_rst_locked0", locked0, 1);
    do_reset();
    for (int i = 0; i < 30; i++) begin
      word(0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) gap();
    end
    probe();
    chk("gaps_locked0", locked0, 1);
    chk("gaps_cnt0", cnt0, 0);
    chk("gaps_cnt1", cnt1, 0);

`ifdef LFSR_CHECKER_BITERR_EN
    word(32'h0000_0111);
    probe();
    chk("biterr_cnt0", cnt0, 3);
    chk("biterr_pulse0", pulse0, 1);
`endif

    // Random soak against the reference model
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 31);
      if (r < 3) gap();
      else if (r == 3) word(rnd_nz(), $urandom_range(0, 3) == 0);
      else if (r == 4) repeat ($urandom_range(1, 5)) word(rnd_nz());
      else if (r == 5) word(32'h1 << $urandom_range(0, 31));
      else word(0, $urandom_range(0, 63) == 0);
    end

    probe();
    probe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
